// File: rtl/axis_lfsr_checker.sv
// rtl/axis_lfsr_checker.sv - AXI-Stream sink that regenerates num_gen LFSR traffic and counts beat errors
module axis_lfsr_checker #(
  parameter int                   TDATAW        = 32,
  parameter int                   TDESTW        = 4,
  parameter int                   LFSR_DW       = 8,
  parameter logic [LFSR_DW-1:0]   LFSR_DEFAULT  = 8'h01,
  parameter int                   PKT_LEN       = 4,
  parameter int                   NUM_PKTS      = 16,
  parameter bit                   CHECK_TDEST   = 1'b0,
  parameter logic [7:0]           READY_PATTERN = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [TDESTW-1:0] exp_tdest,
  input  logic              axis_s_tvalid,
  output logic              axis_s_tready,
  input  logic [TDATAW-1:0] axis_s_tdata,
  input  logic              axis_s_tlast,
  input  logic [TDESTW-1:0] axis_s_tdest,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       err_cnt,
  output logic              error,
  output logic              done,
  output logic [TDATAW-1:0] last_data
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int             BCW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BCW-1:0] BEAT_LAST  = BCW'(PKT_LEN - 1);
  localparam logic [15:0]    NUM_PKTS_W = 16'(NUM_PKTS);

  logic [1:0]         state;
  logic [7:0]         mask;
  logic [LFSR_DW-1:0] lfsr;
  logic [BCW-1:0]     beat_cnt;
  logic               accept;
  logic               exp_last;
  logic               feedback;
  logic               beat_err;

  // Ready comes only from flops, so it never depends on the sender's valid.
  assign axis_s_tready = (state == ST_RECV) && mask[0];
  assign accept        = axis_s_tvalid && axis_s_tready;
  assign exp_last      = (beat_cnt == BEAT_LAST);
  assign feedback      = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign beat_err      = (axis_s_tdata != TDATAW'(lfsr)) ||
                         (axis_s_tlast != exp_last) ||
                         (CHECK_TDEST && (axis_s_tdest != exp_tdest));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mask      <= READY_PATTERN;
      lfsr      <= LFSR_DEFAULT;
      beat_cnt  <= '0;
      pkt_cnt   <= 16'd0;
      err_cnt   <= 16'd0;
      error     <= 1'b0;
      done      <= 1'b0;
      last_data <= '0;
    end else if (start && (state != ST_RECV)) begin
      state    <= ST_RECV;
      mask     <= READY_PATTERN;
      lfsr     <= LFSR_DEFAULT;
      beat_cnt <= '0;
      pkt_cnt  <= 16'd0;
      err_cnt  <= 16'd0;
      error    <= 1'b0;
      done     <= 1'b0;
    end else if (state == ST_RECV) begin
      mask <= {mask[0], mask[7:1]};
      if (accept) begin
        // The LFSR advances on every beat, good or bad: no resync to the sender.
        lfsr      <= {lfsr[LFSR_DW-2:0], feedback};
        beat_cnt  <= (axis_s_tlast || exp_last) ? '0 : beat_cnt + 1'b1;
        last_data <= axis_s_tdata;
        if (beat_err) begin
          error <= 1'b1;
          if (err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
          end
        end
        if (axis_s_tlast) begin
          pkt_cnt <= pkt_cnt + 16'd1;
          if ((pkt_cnt + 16'd1) == NUM_PKTS_W) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
      end
    end
  end

endmodule
